fpu_ss_instr_buffer: RTL and testbench
======================================

# fpu_ss_instr_buffer

Instruction buffer at the front of the FPU subsystem. It accepts offloaded instructions and their integer operands from the core's offload request channel and stores them in a circular FIFO. It presents the oldest entry to the FPU subsystem controller through a pop valid/ready handshake. Empty-side outputs are masked so the controller never sees stale entries.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ID_WIDTH, 4, width of the offload transaction ID.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  synchronous clear of all entries.
- c_q_valid_i  input  1  offload request valid.
- c_q_ready_o  output  1  buffer can accept a request this cycle.
- c_q_instr_i  input  32  instruction word.
- c_q_rs1_i  input  32  integer operand rs1.
- c_q_rs2_i  input  32  integer operand rs2.
- c_q_id_i  input  ID_WIDTH  transaction ID.
- pop_valid_o  output  1  the head entry is valid (buffer is not empty).
- pop_ready_i  input  1  controller consumes the head entry.
- pop_instr_o  output  32  head instruction.
- pop_rs1_o  output  32  head rs1 operand.
- pop_rs2_o  output  32  head rs2 operand.
- pop_id_o  output  ID_WIDTH  head transaction ID.
- usage_o  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {instr, rs1, rs2, id}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide, wrap modulo DEPTH.
- Count: a $clog2(DEPTH)+1 bit count register; usage_o = count.
- Flags: full = (count == DEPTH); empty = (count == 0).
- Push: push = c_q_valid_i & c_q_ready_o.
  - Writes the request to mem[wr_ptr].
  - Increments wr_ptr.
- c_q_ready_o = ~full & ~flush_i.
  - A pop in the same cycle does not free a slot for a push; there is no pass-through when full.
- Pop: pop = pop_valid_o & pop_ready_i.
  - Increments rd_ptr.
  - pop_ready_i while empty is ignored; no pointer or count change.
- pop_valid_o = ~empty.
- Pop data:
  - When not empty, pop_*_o come combinationally from mem[rd_ptr].
  - When empty, all pop_*_o are driven to 0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Flush, highest priority:
  - wr_ptr, rd_ptr and count go to 0 on the next edge.
  - A push or pop in the flush cycle has no effect.
  - Memory contents are not cleared.
- No internal state machine beyond the pointers and count. Order is strict FIFO.

## Timing
- Reset values:
  - wr_ptr = rd_ptr = count = 0.
  - Memory is cleared to 0.
  - c_q_ready_o = 1, pop_valid_o = 0, pop_*_o = 0, usage_o = 0.
- Reset is honoured mid-operation; all entries are discarded asynchronously.
- Latency: a request pushed at edge N is visible as pop_valid_o = 1 in the cycle after edge N. There is no same-cycle fall-through from c_q to pop.
- Pop: an entry popped at edge N is replaced by the next entry, or by the zeroed empty outputs, in the cycle after edge N.
- Full boundary:
  - count == DEPTH gives c_q_ready_o = 0.
  - It returns to 1 in the cycle after the first pop.
- Empty boundary: count == 0 gives pop_valid_o = 0 and zeroed data, even though the memory slot at rd_ptr holds old data.
- Wrap-around: the pointers roll from DEPTH-1 to 0 transparently. Full and empty are decided by count, never by pointer equality.
- Simultaneous push and pop at count = 1: the count stays 1 and the head advances to the newly pushed entry on the next cycle.
- Flush in the cycle after a push: the pushed entry is discarded and pop_valid_o = 0 in the following cycle.
- Handshake rules:
  - c_q_ready_o does not depend on c_q_valid_i.
  - pop_valid_o does not depend on pop_ready_i.
  - There are no combinational loops.

## Test plan
- Reset, then push instr 0x00107053, rs1 0x11, rs2 0x22, id 3. Required: pop_valid_o = 1 the next cycle, pop_instr_o = 0x00107053, pop_id_o = 3, usage_o = 1. Then pop once: pop_valid_o = 0, all pop data 0, usage_o = 0.
- Fill a DEPTH=4 buffer with ids 0..3. Required: c_q_ready_o = 0 and usage_o = 4. Then hold c_q_valid_i with pop_ready_i = 1 in one cycle. Required: the push is refused, usage_o = 3, and c_q_ready_o = 1 in the next cycle.
- Continuous push and pop for 10 entries with ids 0..9 (pointer wrap). Required: pops return ids 0..9 in order with no loss or duplication, and usage_o never exceeds 4.
- Simultaneous push and pop at usage 2. Required: usage_o stays 2 and FIFO order is preserved.
- Three entries held, then flush_i = 1 together with c_q_valid_i = 1. Required: c_q_ready_o = 0 in the flush cycle, then usage_o = 0, pop_valid_o = 0 and pop data 0 in the next cycle.
- Assert rst_ni = 0 asynchronously mid-cycle with 2 entries held. Required: pop_valid_o = 0, usage_o = 0 and c_q_ready_o = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_ss_instr_buffer.sv
// Offload instruction buffer: circular FIFO of {instr, rs1, rs2, id}
// with zero-masked head outputs while empty.
module fpu_ss_instr_buffer #(
   parameter int DEPTH    = 4,
   parameter int ID_WIDTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     c_q_valid_i,
   output logic                     c_q_ready_o,
   input  logic [31:0]              c_q_instr_i,
   input  logic [31:0]              c_q_rs1_i,
   input  logic [31:0]              c_q_rs2_i,
   input  logic [ID_WIDTH-1:0]      c_q_id_i,
   output logic                     pop_valid_o,
   input  logic                     pop_ready_i,
   output logic [31:0]              pop_instr_o,
   output logic [31:0]              pop_rs1_o,
   output logic [31:0]              pop_rs2_o,
   output logic [ID_WIDTH-1:0]      pop_id_o,
   output logic [$clog2(DEPTH):0]   usage_o
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0]         instr;
      logic [31:0]         rs1;
      logic [31:0]         rs2;
      logic [ID_WIDTH-1:0] id;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        wr_entry;
   entry_t        head;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

   // Ready ignores pop: a slot freed this cycle is only reusable next cycle.
   assign c_q_ready_o = ~full & ~flush_i;
   assign pop_valid_o = ~empty;
   assign push        = c_q_valid_i & c_q_ready_o;
   assign pop         = pop_valid_o & pop_ready_i;
   assign usage_o     = count_q;

   assign wr_entry = '{
      instr: c_q_instr_i,
      rs1:   c_q_rs1_i,
      rs2:   c_q_rs2_i,
      id:    c_q_id_i
   };

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Mask stale memory so an empty buffer always presents zeros.
   assign head = empty ? '0 : mem_q[rd_ptr_q];

   assign pop_instr_o = head.instr;
   assign pop_rs1_o   = head.rs1;
   assign pop_rs2_o   = head.rs2;
   assign pop_id_o    = head.id;

endmodule

// File: tb/tb_fpu_ss_instr_buffer.sv
// Bench for fpu_ss_instr_buffer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fpu_ss_instr_buffer;

   localparam int DEPTH = 4;
   localparam int IDW   = 4;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           flush_i;
   logic           c_q_valid_i;
   logic           c_q_ready_o;
   logic [31:0]    c_q_instr_i;
   logic [31:0]    c_q_rs1_i;
   logic [31:0]    c_q_rs2_i;
   logic [IDW-1:0] c_q_id_i;
   logic           pop_valid_o;
   logic           pop_ready_i;
   logic [31:0]    pop_instr_o;
   logic [31:0]    pop_rs1_o;
   logic [31:0]    pop_rs2_o;
   logic [IDW-1:0] pop_id_o;
   logic [2:0]     usage_o;

   typedef struct {
      logic [31:0]    instr;
      logic [31:0]    rs1;
      logic [31:0]    rs2;
      logic [IDW-1:0] id;
   } ent_t;

   ent_t model_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   popped[$];
   int   max_use;

   fpu_ss_instr_buffer #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .c_q_valid_i (c_q_valid_i),
      .c_q_ready_o (c_q_ready_o),
      .c_q_instr_i (c_q_instr_i),
      .c_q_rs1_i   (c_q_rs1_i),
      .c_q_rs2_i   (c_q_rs2_i),
      .c_q_id_i    (c_q_id_i),
      .pop_valid_o (pop_valid_o),
      .pop_ready_i (pop_ready_i),
      .pop_instr_o (pop_instr_o),
      .pop_rs1_o   (pop_rs1_o),
      .pop_rs2_o   (pop_rs2_o),
      .pop_id_o    (pop_id_o),
      .usage_o     (usage_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Reference model: a plain queue bounded at DEPTH.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         model_q.delete();
      end else if (flush_i) begin
         model_q.delete();
      end else begin
         automatic bit do_pop  = pop_ready_i && (model_q.size() > 0);
         automatic bit do_push = c_q_valid_i && (model_q.size() < DEPTH);
         automatic ent_t e;
         e.instr = c_q_instr_i;
         e.rs1   = c_q_rs1_i;
         e.rs2   = c_q_rs2_i;
         e.id    = c_q_id_i;
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back(e);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         automatic int   sz = model_q.size();
         automatic ent_t h = '{default: '0};
         if (sz > 0) h = model_q[0];
         check("m_ready", 32'(c_q_ready_o),
               32'((sz < DEPTH) && !flush_i));
         check("m_valid", 32'(pop_valid_o), 32'(sz > 0));
         check("m_usage", 32'(usage_o), 32'(sz));
         check("m_instr", pop_instr_o, h.instr);
         check("m_rs1", pop_rs1_o, h.rs1);
         check("m_rs2", pop_rs2_o, h.rs2);
         check("m_id", 32'(pop_id_o), 32'(h.id));
      end
   end

   task automatic idle();
      c_q_valid_i = 1'b0;
      pop_ready_i = 1'b0;
      flush_i     = 1'b0;
      c_q_instr_i = '0;
      c_q_rs1_i   = '0;
      c_q_rs2_i   = '0;
      c_q_id_i    = '0;
   endtask

   task automatic set_req(input logic [31:0] ins,
                          input logic [31:0] r1,
                          input logic [31:0] r2,
                          input int id);
      c_q_valid_i = 1'b1;
      c_q_instr_i = ins;
      c_q_rs1_i   = r1;
      c_q_rs2_i   = r2;
      c_q_id_i    = IDW'(id);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      idle();
   endtask

   task automatic push(input int id);
      set_req(32'hA000_0000 + 32'(id), 32'(id) << 4, 32'(id) << 8, id);
      step();
   endtask

   initial begin
      rst_ni = 1'b0;
      idle();
      #12;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      check("rst_valid", 32'(pop_valid_o), 32'd0);
      check("rst_ready", 32'(c_q_ready_o), 32'd1);
      check("rst_usage", 32'(usage_o), 32'd0);
      check("rst_instr", pop_instr_o, 32'd0);

      // Single push then pop.
      set_req(32'h0010_7053, 32'h11, 32'h22, 3);
      step();
      check("t1_valid", 32'(pop_valid_o), 32'd1);
      check("t1_instr", pop_instr_o, 32'h0010_7053);
      check("t1_rs1", pop_rs1_o, 32'h11);
      check("t1_rs2", pop_rs2_o, 32'h22);
      check("t1_id", 32'(pop_id_o), 32'd3);
      check("t1_usage", 32'(usage_o), 32'd1);
      pop_ready_i = 1'b1;
      step();
      check("t1_pvalid", 32'(pop_valid_o), 32'd0);
      check("t1_pinstr", pop_instr_o, 32'd0);
      check("t1_prs1", pop_rs1_o, 32'd0);
      check("t1_prs2", pop_rs2_o, 32'd0);
      check("t1_pid", 32'(pop_id_o), 32'd0);
      check("t1_pusage", 32'(usage_o), 32'd0);

      // Fill to full, then push+pop together: push refused.
      for (int i = 0; i < 4; i++) push(i);
      check("t2_ready", 32'(c_q_ready_o), 32'd0);
      check("t2_usage", 32'(usage_o), 32'd4);
      check("t2_head", 32'(pop_id_o), 32'd0);
      set_req(32'hDEAD_BEEF, 32'd0, 32'd0, 9);
      pop_ready_i = 1'b1;
      #1;
      check("t2_ready_in", 32'(c_q_ready_o), 32'd0);
      step();
      check("t2_usage3", 32'(usage_o), 32'd3);
      check("t2_ready1", 32'(c_q_ready_o), 32'd1);
      check("t2_head1", 32'(pop_id_o), 32'd1);
      for (int i = 1; i < 4; i++) begin
         check("t2_drain", 32'(pop_id_o), 32'(i));
         pop_ready_i = 1'b1;
         step();
      end
      check("t2_empty", 32'(pop_valid_o), 32'd0);

      // Streaming 10 entries across the pointer wrap.
      begin
         automatic int sent = 0;
         popped.delete();
         max_use = 0;
         for (int c = 0; c < 40 && popped.size() < 10; c++) begin
            if (sent < 10) set_req(32'h100 + 32'(sent), 32'd0, 32'd0, sent);
            pop_ready_i = 1'b1;
            #1;
            if (int'(usage_o) > max_use) max_use = int'(usage_o);
            if (pop_valid_o) popped.push_back(int'(pop_id_o));
            if (c_q_valid_i && c_q_ready_o) sent++;
            step();
         end
         check("t3_count", 32'(popped.size()), 32'd10);
         for (int i = 0; i < popped.size() && i < 10; i++)
            check("t3_order", 32'(popped[i]), 32'(i));
         check("t3_maxuse_le4", 32'(max_use <= 4), 32'd1);
      end
      idle();
      step();

      // Simultaneous push and pop at usage 2.
      push(5);
      push(6);
      check("t4_usage", 32'(usage_o), 32'd2);
      set_req(32'h7, 32'd0, 32'd0, 7);
      pop_ready_i = 1'b1;
      step();
      check("t4_usage2", 32'(usage_o), 32'd2);
      check("t4_head6", 32'(pop_id_o), 32'd6);
      pop_ready_i = 1'b1;
      step();
      check("t4_head7", 32'(pop_id_o), 32'd7);
      pop_ready_i = 1'b1;
      step();
      check("t4_empty", 32'(usage_o), 32'd0);

      // Flush with a concurrent push.
      push(1);
      push(2);
      push(3);
      set_req(32'h44, 32'd0, 32'd0, 4);
      flush_i = 1'b1;
      #1;
      check("t5_ready", 32'(c_q_ready_o), 32'd0);
      step();
      check("t5_usage", 32'(usage_o), 32'd0);
      check("t5_valid", 32'(pop_valid_o), 32'd0);
      check("t5_instr", pop_instr_o, 32'd0);
      check("t5_id", 32'(pop_id_o), 32'd0);

      // Asynchronous reset mid-cycle.
      push(8);
      push(9);
      check("t6_usage", 32'(usage_o), 32'd2);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6_valid", 32'(pop_valid_o), 32'd0);
      check("t6_usage0", 32'(usage_o), 32'd0);
      check("t6_ready", 32'(c_q_ready_o), 32'd1);
      #3;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      push(10);
      check("t6_after", 32'(pop_id_o), 32'd10);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
